// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan monitor: glyph patterns, scan
// FSM states and the successor rule used by the step check.
package seg_pkg;

  // Decimal point position in the display bus; the monitor ignores it.
  localparam int DP_BIT = 0;

  // Active-low glyphs, bit 6 = segment a down to bit 0 = segment g.
  localparam logic [6:0] GLYPH_0 = 7'b000_0001;
  localparam logic [6:0] GLYPH_1 = 7'b100_1111;
  localparam logic [6:0] GLYPH_2 = 7'b001_0010;
  localparam logic [6:0] GLYPH_3 = 7'b000_0110;
  localparam logic [6:0] GLYPH_4 = 7'b100_1100;
  localparam logic [6:0] GLYPH_5 = 7'b010_0100;
  localparam logic [6:0] GLYPH_6 = 7'b010_0000;
  localparam logic [6:0] GLYPH_7 = 7'b000_1111;
  localparam logic [6:0] GLYPH_8 = 7'b000_0000;
  localparam logic [6:0] GLYPH_9 = 7'b000_0100;
  localparam logic [6:0] GLYPH_A = 7'b000_1000;
  localparam logic [6:0] GLYPH_B = 7'b110_0000;
  localparam logic [6:0] GLYPH_C = 7'b011_0001;
  localparam logic [6:0] GLYPH_D = 7'b100_0010;
  localparam logic [6:0] GLYPH_E = 7'b011_0000;
  localparam logic [6:0] GLYPH_F = 7'b011_1000;

  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } scan_state_e;

  // Value the counter should show next, modulo 256.
  function automatic logic [7:0] successor(input logic [7:0] v, input logic down);
    return down ? (v - 8'd1) : (v + 8'd1);
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational glyph decoder: maps an active-low a..g pattern to its hex
// nibble and flags patterns that are not one of the sixteen hex glyphs.
module seg7_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    // NOTE: defaults before the search keep this purely combinational; an
    // unassigned path here would infer a latch.
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitor for a multiplexed two-digit 7-segment display: debounces each digit,
// rebuilds the shown byte from lo/hi scan pairs and checks the count sequence.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          CHECK_DOWN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] display,
  input  logic       ctrl,
  output logic [7:0] value,
  output logic       valid,
  output logic       step_ok,
  output logic       step_err,
  output logic       invalid_seg
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [7:0]  in_vec;
  logic        unused_dp;
  logic [7:0]  samp;
  logic [7:0]  cnt;
  logic        taken;
  logic        in_changed;
  logic        accept;
  logic [3:0]  nibble;
  logic        legal;
  logic [3:0]  lo_pend;
  scan_state_e state_q;
  scan_state_e state_d;
  logic        lo_load;
  logic        scan_done;
  logic        glyph_bad;
  logic [7:0]  scan_val;
  logic [7:0]  expect_val;
  logic        commit_seed;
  logic        commit_step;

  assign in_vec     = {display[7:1], ctrl};
  assign unused_dp  = display[DP_BIT];
  assign in_changed = (in_vec != samp);
  // A sample is taken exactly once per stable run, the cycle the run length
  // reaches the threshold.
  assign accept     = (cnt == STABLE_CNT) && !taken;

  always_ff @(posedge clk) begin
    // NOTE: every state register uses <= so all flops see pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      samp  <= '1;
      cnt   <= '0;
      taken <= 1'b0;
    end else begin
      samp <= in_vec;
      if (in_changed) begin
        cnt   <= 8'd1;
        taken <= 1'b0;
      end else begin
        if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        if (accept) taken <= 1'b1;
      end
    end
  end

  seg7_to_hex u_dec (
    .pattern (samp[7:1]),
    .nibble  (nibble),
    .legal   (legal)
  );

  // Scan FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_LO;
    else        state_q <= state_d;
  end

  // Scan FSM: next state. Bad glyphs abort a half-finished scan.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (!legal)                  state_d = WAIT_LO;
      else if (!samp[0])           state_d = WAIT_HI;
      else if (state_q == WAIT_HI) state_d = WAIT_LO;
    end
  end

  // Scan FSM: decoded digit events. A hi digit only counts after a lo digit.
  always_comb begin
    lo_load   = 1'b0;
    scan_done = 1'b0;
    glyph_bad = 1'b0;
    if (accept) begin
      if (!legal)                  glyph_bad = 1'b1;
      else if (!samp[0])           lo_load   = 1'b1;
      else if (state_q == WAIT_HI) scan_done = 1'b1;
    end
  end

  assign scan_val    = {nibble, lo_pend};
  assign expect_val  = successor(value, CHECK_DOWN);
  assign commit_seed = scan_done && !valid;
  assign commit_step = scan_done && valid && (scan_val != value);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_pend     <= 4'h0;
      value       <= 8'h00;
      valid       <= 1'b0;
      step_ok     <= 1'b0;
      step_err    <= 1'b0;
      invalid_seg <= 1'b0;
    end else begin
      step_ok     <= commit_step && (scan_val == expect_val);
      step_err    <= commit_step && (scan_val != expect_val);
      invalid_seg <= glyph_bad;
      if (lo_load) lo_pend <= nibble;
      if (commit_seed || commit_step) value <= scan_val;
      if (commit_seed) valid <= 1'b1;
    end
  end

endmodule
